// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: NOP encoding, fetch FSM states, decoder opcodes.
// No logic; constants and a small helper only.
// Imported by the fetch stage and by the decoder.
package riscv_pkg;

    // addi x0, x0, 0 -- what decode sees while nothing live is presented
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Major opcodes, instr[6:0], shared with the main decoder
    localparam logic [6:0] OPC_R      = 7'b011_0011;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_ALU_I  = 7'b001_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;

    // IDLE: nothing outstanding; WAIT: response will be kept; DRAIN: response will be dropped
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Instructions are word aligned; redirect targets have their low two bits cleared
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle between fetch, instruction memory, decode and the execute redirect path.
// Pure wiring, no latency.
// master = fetch stage; slave = memory/decode/execute environment.
interface fetch_stage_if;

    // instruction memory request/response
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;

    // decode side
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;

    // execute redirect
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, pc_out, pc_plus4,
        input  imem_valid, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, pc_out, pc_plus4,
        output imem_valid, imem_rdata, stall, redirect, redirect_pc
    );

endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem reads, word+PC presented to decode.
// Latency: request cycle N -> instr_valid at N+2 with a 1-cycle memory; 1 instr/cycle sustained.
// Backpressure: stall freezes the output, one extra response parks in a skid entry, issue stops until it drains.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst_n,
    fetch_stage_if.master fi
);

    fetch_state_t state;
    logic [31:0]  fpc;
    logic [31:0]  req_pc;

    logic         out_valid;
    logic [31:0]  out_instr;
    logic [31:0]  out_pc;

    logic         buf_valid;
    logic [31:0]  buf_instr;
    logic [31:0]  buf_pc;

    logic         consume;
    logic         slot_free;
    logic         resp;
    logic         issue;

    // Handshake terms; issue is gated by rst_n so no request leaves while reset is held
    always_comb begin
        consume   = out_valid && !fi.stall;
        slot_free = !out_valid || consume;
        resp      = (state == WAIT) && fi.imem_valid;
        issue     = rst_n && !fi.redirect && !buf_valid &&
                    ((state == IDLE) || (resp && slot_free));
    end

    assign fi.imem_req    = issue;
    assign fi.imem_addr   = fpc;
    assign fi.instr_valid = out_valid;
    assign fi.instr       = out_instr;
    assign fi.pc_out      = out_pc;
    assign fi.pc_plus4    = out_pc + 32'd4;

    // FSM, PC, output slot and skid entry; redirect overrides every other update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fpc       <= RESET_PC;
            req_pc    <= 32'd0;
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
            out_pc    <= 32'd0;
            buf_valid <= 1'b0;
            buf_instr <= NOP_INSTR;
            buf_pc    <= 32'd0;
        end else if (fi.redirect) begin
            out_valid <= 1'b0;
            buf_valid <= 1'b0;
            fpc       <= word_align(fi.redirect_pc);
            case (state)
                // response already here: drop it; otherwise it must be drained
                WAIT:    state <= fi.imem_valid ? IDLE : DRAIN;
                // the old request is still owed a response; if it lands now it is the one being drained
                DRAIN:   state <= fi.imem_valid ? IDLE : DRAIN;
                default: state <= IDLE;
            endcase
        end else begin
            // decode took the current word: refill from the skid entry, or empty the slot
            if (consume) begin
                if (buf_valid) begin
                    out_instr <= buf_instr;
                    out_pc    <= buf_pc;
                    buf_valid <= 1'b0;
                end else if (!resp) begin
                    out_valid <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    if (issue) state <= WAIT;
                end
                WAIT: begin
                    if (fi.imem_valid) begin
                        if (slot_free) begin
                            out_valid <= 1'b1;
                            out_instr <= fi.imem_rdata;
                            out_pc    <= req_pc;
                        end else begin
                            buf_valid <= 1'b1;
                            buf_instr <= fi.imem_rdata;
                            buf_pc    <= req_pc;
                        end
                        state <= issue ? WAIT : IDLE;
                    end
                end
                DRAIN: begin
                    // stale data from before the redirect; nothing issues this cycle
                    if (fi.imem_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (issue) begin
                req_pc <= fpc;
                fpc    <= fpc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import riscv_pkg::*;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fetch_stage_if fi ();

    fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fi    (fi)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] p4;
    } out_t;

    out_t        exp_out[$];
    logic [31:0] exp_req[$];

    int n_cmp = 0;
    int n_bad = 0;

    // memory model controls
    int          lat   = 1;
    bit          flush = 1'b0;
    bit          pend  = 1'b0;
    int          cnt   = 0;
    logic [31:0] maddr = 32'd0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic [31:0] a);
        exp_req.push_back(a);
    endtask

    task automatic push_out(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] p4);
        out_t o;
        o.pc = pc; o.ins = ins; o.p4 = p4;
        exp_out.push_back(o);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic end_phase(input string name);
        #3;
        check32({name, "_req_left"}, 32'(exp_req.size()), 32'd0);
        check32({name, "_out_left"}, 32'(exp_out.size()), 32'd0);
        exp_req.delete();
        exp_out.delete();
    endtask

    // reset with a flushed memory; returns at the negedge where rst_n rises (cycle 0)
    task automatic do_reset(input int l);
        @(negedge clk);
        rst_n = 1'b0;
        lat   = l;
        flush = 1'b1;
        steps(3);
        flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // instruction memory: fixed latency, data = addr>>2, checks each request against exp_req
    initial begin
        fi.imem_valid = 1'b0;
        fi.imem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (flush) begin
                pend = 1'b0;
                fi.imem_valid = 1'b0;
            end else if (pend && cnt == 1) begin
                fi.imem_valid = 1'b1;
                fi.imem_rdata = maddr >> 2;
                pend = 1'b0;
            end else begin
                fi.imem_valid = 1'b0;
                if (pend) cnt--;
            end
            #1;
            if (fi.imem_req === 1'b1) begin
                pend  = 1'b1;
                cnt   = lat;
                maddr = fi.imem_addr;
                if (exp_req.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL req_unexpected: got request to %h, required none", fi.imem_addr);
                end else begin
                    check32("req_addr", fi.imem_addr, exp_req.pop_front());
                end
            end
        end
    end

    // output monitor: every consumed word is checked against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && fi.instr_valid === 1'b1 && fi.stall === 1'b0) begin
                if (exp_out.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL out_unexpected: got pc %h instr %h, required nothing", fi.pc_out, fi.instr);
                end else begin
                    out_t e;
                    e = exp_out.pop_front();
                    check32("out_pc", fi.pc_out, e.pc);
                    check32("out_instr", fi.instr, e.ins);
                    check32("out_pc_plus4", fi.pc_plus4, e.p4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        fi.stall       = 1'b0;
        fi.redirect    = 1'b0;
        fi.redirect_pc = 32'd0;

        // reset values
        #12;
        check32("rst_instr_valid", 32'(fi.instr_valid), 32'd0);
        check32("rst_instr", fi.instr, 32'h0000_0013);
        check32("rst_pc_out", fi.pc_out, 32'd0);
        check32("rst_pc_plus4", fi.pc_plus4, 32'd4);
        check32("rst_imem_req", 32'(fi.imem_req), 32'd0);

        // streaming with a 4-cycle stall, 1-cycle memory
        for (int i = 0; i < 5; i++) push_req(32'h100 + 32'(4 * i));
        push_req(32'h114); push_req(32'h118); push_req(32'h11C); push_req(32'h120);
        push_out(32'h100, 32'h40, 32'h104);
        push_out(32'h104, 32'h41, 32'h108);
        push_out(32'h108, 32'h42, 32'h10C);
        push_out(32'h10C, 32'h43, 32'h110);
        push_out(32'h110, 32'h44, 32'h114);
        push_out(32'h114, 32'h45, 32'h118);
        push_out(32'h118, 32'h46, 32'h11C);
        do_reset(1);
        step(); #2;
        check32("first_gap_valid", 32'(fi.instr_valid), 32'd0);
        step(); #2;
        check32("first_valid", 32'(fi.instr_valid), 32'd1);
        check32("first_pc", fi.pc_out, 32'h100);
        steps(2);
        for (int c = 5; c <= 8; c++) begin
            step();
            fi.stall = 1'b1;
            #2;
            check32("stall_pc", fi.pc_out, 32'h10C);
            check32("stall_instr", fi.instr, 32'h43);
            check32("stall_req", 32'(fi.imem_req), 32'd0);
        end
        step();
        fi.stall = 1'b0;
        step(); #2;
        check32("unstall_valid", 32'(fi.instr_valid), 32'd1);
        check32("unstall_pc", fi.pc_out, 32'h110);
        steps(3);
        end_phase("stream");

        // redirect while a request is outstanding, 3-cycle memory
        push_req(32'h100); push_req(32'h104); push_req(32'h108); push_req(32'h10C);
        push_req(32'h200); push_req(32'h204);
        push_out(32'h100, 32'h40, 32'h104);
        push_out(32'h104, 32'h41, 32'h108);
        push_out(32'h108, 32'h42, 32'h10C);
        push_out(32'h200, 32'h80, 32'h204);
        do_reset(3);
        steps(11);
        fi.redirect = 1'b1;
        fi.redirect_pc = 32'h200;
        #2;
        check32("redir_req_suppressed", 32'(fi.imem_req), 32'd0);
        step();
        fi.redirect = 1'b0;
        #2;
        check32("redir_valid_cleared", 32'(fi.instr_valid), 32'd0);
        check32("drain_no_req", 32'(fi.imem_req), 32'd0);
        step(); #2;
        check32("after_drain_req", 32'(fi.imem_req), 32'd1);
        check32("after_drain_addr", fi.imem_addr, 32'h200);
        steps(4);
        end_phase("redirect_wait");

        // redirect coinciding with the response, 3-cycle memory
        push_req(32'h100); push_req(32'h300); push_req(32'h304);
        push_out(32'h300, 32'hC0, 32'h304);
        do_reset(3);
        steps(3);
        fi.redirect = 1'b1;
        fi.redirect_pc = 32'h300;
        #2;
        check32("coinc_req_suppressed", 32'(fi.imem_req), 32'd0);
        step();
        fi.redirect = 1'b0;
        #2;
        check32("coinc_next_req", 32'(fi.imem_req), 32'd1);
        check32("coinc_next_addr", fi.imem_addr, 32'h300);
        steps(4);
        end_phase("redirect_coinc");

        // redirect to the top of the address space: PC wraps to 0
        push_req(32'hFFFF_FFFC); push_req(32'h0); push_req(32'h4); push_req(32'h8);
        push_out(32'hFFFF_FFFC, 32'h3FFF_FFFF, 32'h0);
        push_out(32'h0, 32'h0, 32'h4);
        do_reset(1);
        fi.redirect = 1'b1;
        fi.redirect_pc = 32'hFFFF_FFFC;
        step();
        fi.redirect = 1'b0;
        #2;
        check32("wrap_addr", fi.imem_addr, 32'hFFFF_FFFC);
        steps(3);
        end_phase("wrap");

        // unaligned redirect target is fetched word aligned
        push_req(32'h200); push_req(32'h204); push_req(32'h208);
        push_out(32'h200, 32'h80, 32'h204);
        do_reset(1);
        fi.redirect = 1'b1;
        fi.redirect_pc = 32'h203;
        step();
        fi.redirect = 1'b0;
        #2;
        check32("align_addr", fi.imem_addr, 32'h200);
        steps(2);
        end_phase("align");

        // asynchronous reset mid-WAIT; the late response must not surface
        push_req(32'h100); push_req(32'h104); push_req(32'h100); push_req(32'h104);
        push_out(32'h100, 32'h40, 32'h104);
        do_reset(3);
        steps(4);
        fi.stall = 1'b1;
        #2;
        check32("pre_arst_valid", 32'(fi.instr_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check32("arst_valid", 32'(fi.instr_valid), 32'd0);
        check32("arst_pc_out", fi.pc_out, 32'd0);
        check32("arst_instr", fi.instr, 32'h0000_0013);
        check32("arst_pc_plus4", fi.pc_plus4, 32'd4);
        check32("arst_req", 32'(fi.imem_req), 32'd0);
        step();
        fi.stall = 1'b0;
        step();
        rst_n = 1'b1;
        #2;
        check32("rearm_req", 32'(fi.imem_req), 32'd1);
        check32("rearm_addr", fi.imem_addr, 32'h100);
        for (int c = 7; c <= 9; c++) begin
            step(); #2;
            check32("late_resp_ignored", 32'(fi.instr_valid), 32'd0);
        end
        step();
        end_phase("arst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
